// File: rtl/oqpsk_chip_spreader_pkg.sv
// Shared types, constants and the IEEE 802.15.4 2.4 GHz chip table for the O-QPSK spreader.
package oqpsk_pkg;

  localparam int unsigned CHIPS_PER_SYM = 32;
  localparam int unsigned SYM_BITS      = 4;

  typedef logic [31:0] chip_seq_t;

  typedef enum logic [1:0] {
    F_IDLE,
    F_READ,
    F_WAIT,
    F_HOLD
  } fetch_state_t;

  localparam chip_seq_t CHIP_BASE     = 32'h744AC39B;
  localparam chip_seq_t ODD_CHIP_MASK = 32'hAAAAAAAA;

  // Symbols 1-7 are symbol 0 rotated left by 4*k chips; symbols 8-15 also invert the odd chips.
  function automatic chip_seq_t chip_lut(input logic [SYM_BITS-1:0] sym);
    logic [63:0] rot;
    rot = {CHIP_BASE, CHIP_BASE} << {sym[2:0], 2'b00};
    return sym[3] ? (rot[63:32] ^ ODD_CHIP_MASK) : rot[63:32];
  endfunction

endpackage

// File: rtl/oqpsk_chip_spreader_if.sv
// FIFO-side and modulator-side signals of the chip spreader; optional inBypass under OQPSK_CHIP_SPREADER_BYPASS_EN.
interface oqpsk_chip_spreader_if;
  logic inFifoData;
  logic inFifoEmpty;
  logic outFifoReadEnable;
  logic inReady;
  logic outChip;
  logic outEmpty;
  logic outSymbolDone;
`ifdef OQPSK_CHIP_SPREADER_BYPASS_EN
  logic inBypass;
`endif

  modport master (
`ifdef OQPSK_CHIP_SPREADER_BYPASS_EN
    input  inBypass,
`endif
    input  inFifoData,
    input  inFifoEmpty,
    input  inReady,
    output outFifoReadEnable,
    output outChip,
    output outEmpty,
    output outSymbolDone
  );

  modport slave (
`ifdef OQPSK_CHIP_SPREADER_BYPASS_EN
    output inBypass,
`endif
    output inFifoData,
    output inFifoEmpty,
    output inReady,
    input  outFifoReadEnable,
    input  outChip,
    input  outEmpty,
    input  outSymbolDone
  );
endinterface

// File: rtl/oqpsk_chip_spreader_bit_collector.sv
// Fetch FSM: pulls serial bits from the FIFO, assembles an LSB-first symbol and holds it for the send path.
module oqpsk_bit_collector
  import oqpsk_pkg::*;
#(
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                fifo_data_i,
  input  logic                fifo_empty_i,
  output logic                fifo_rd_o,
  input  logic                single_i,
  output logic                hold_valid_o,
  output logic [SYM_BITS-1:0] hold_data_o,
  input  logic                hold_take_i
);

  localparam logic [1:0] LAT_LAST = 2'(RD_LATENCY - 1);
  localparam logic [1:0] BIT_LAST = 2'(SYM_BITS - 1);

  fetch_state_t        state_q, state_d;
  logic [1:0]          bitcnt_q, bitcnt_d;
  logic [1:0]          wcnt_q, wcnt_d;
  logic [SYM_BITS-1:0] hold_q, hold_d;
  logic                hv_q, hv_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= F_IDLE;
      bitcnt_q <= '0;
      wcnt_q   <= '0;
      hold_q   <= '0;
      hv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      wcnt_q   <= wcnt_d;
      hold_q   <= hold_d;
      hv_q     <= hv_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    wcnt_d   = wcnt_q;
    hold_d   = hold_q;
    hv_d     = hv_q;
    if (hold_take_i) hv_d = 1'b0;
    case (state_q)
      F_IDLE: if (!hv_q) state_d = F_READ;
      F_READ: begin
        if (!fifo_empty_i) begin
          state_d = F_WAIT;
          wcnt_d  = '0;
        end
      end
      F_WAIT: begin
        if (wcnt_q == LAT_LAST) begin
          hold_d[bitcnt_q] = fifo_data_i;
          if (bitcnt_q == BIT_LAST || single_i) begin
            hv_d    = 1'b1;
            state_d = F_HOLD;
          end else begin
            bitcnt_d = bitcnt_q + 2'd1;
            state_d  = F_READ;
          end
        end else begin
          wcnt_d = wcnt_q + 2'd1;
        end
      end
      F_HOLD: begin
        if (hold_take_i) begin
          state_d  = F_IDLE;
          bitcnt_d = '0;
        end
      end
      default: state_d = F_IDLE;
    endcase
  end

  always_comb begin
    fifo_rd_o    = (state_q == F_READ) && !fifo_empty_i && !rst_i;
    hold_valid_o = hv_q;
    hold_data_o  = hold_q;
  end

endmodule

// File: rtl/oqpsk_chip_spreader.sv
// O-QPSK chip spreader: symbol-to-PN mapping with double buffering; bypass mode via OQPSK_CHIP_SPREADER_BYPASS_EN.
module oqpsk_chip_spreader #(
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned SYM_BITS   = 4
) (
  input logic                   inClock,
  input logic                   inReset,
  oqpsk_chip_spreader_if.master bus
);
  import oqpsk_pkg::*;

  logic                hold_valid;
  logic                hold_take;
  logic [SYM_BITS-1:0] hold_data;
  logic                single_mode;
  logic                consume, last, load;

  chip_seq_t  sr_q, sr_d;
  logic [4:0] cnt_q, cnt_d;
  logic       valid_q, valid_d;

`ifdef OQPSK_CHIP_SPREADER_BYPASS_EN
  logic mode_q;

  // Mode only switches when nothing is buffered, so mode_q always describes the send register.
  always_ff @(posedge inClock) begin
    if (inReset) mode_q <= 1'b0;
    else if (!valid_q && !hold_valid) mode_q <= bus.inBypass;
  end
  assign single_mode = mode_q;
`else
  assign single_mode = 1'b0;
`endif

  oqpsk_bit_collector #(
    .RD_LATENCY(RD_LATENCY)
  ) u_collector (
    .clk_i        (inClock),
    .rst_i        (inReset),
    .fifo_data_i  (bus.inFifoData),
    .fifo_empty_i (bus.inFifoEmpty),
    .fifo_rd_o    (bus.outFifoReadEnable),
    .single_i     (single_mode),
    .hold_valid_o (hold_valid),
    .hold_data_o  (hold_data),
    .hold_take_i  (hold_take)
  );

  always_ff @(posedge inClock) begin
    if (inReset) begin
      sr_q    <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  // A load overrides the shift of the final chip so the next symbol follows without a gap.
  always_comb begin
    consume   = bus.inReady && valid_q;
    last      = consume && (single_mode || cnt_q == 5'(CHIPS_PER_SYM - 1));
    load      = hold_valid && (!valid_q || last);
    hold_take = load;
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    valid_d   = valid_q;
    if (consume) begin
      sr_d  = sr_q >> 1;
      cnt_d = cnt_q + 5'd1;
      if (last) valid_d = 1'b0;
    end
    if (load) begin
      sr_d    = single_mode ? {31'b0, hold_data[0]} : chip_lut(hold_data);
      cnt_d   = '0;
      valid_d = 1'b1;
    end
  end

  assign bus.outChip       = sr_q[0];
  assign bus.outEmpty      = !valid_q || inReset;
  assign bus.outSymbolDone = last && !inReset;

endmodule

// File: tb/tb_oqpsk_chip_spreader.sv
// Directed bench for oqpsk_chip_spreader with a behavioural 1-cycle-latency FIFO.
module tb_oqpsk_chip_spreader;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  oqpsk_chip_spreader_if bus();

  oqpsk_chip_spreader #(
    .RD_LATENCY(1),
    .SYM_BITS  (4)
  ) dut (
    .inClock (clk),
    .inReset (rst),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  logic fmem [0:255];
  int   wr_ptr = 0;
  int   rd_ptr = 0;
  logic fdata  = 1'b0;
  int   cyc = 0;
  int   rd_total = 0;
  int   rd_time [0:63];

  assign bus.inFifoEmpty = (wr_ptr == rd_ptr);
  assign bus.inFifoData  = fdata;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.outFifoReadEnable) begin
      fdata <= fmem[rd_ptr[7:0]];
      rd_ptr <= rd_ptr + 1;
      rd_time[rd_total[5:0]] <= cyc;
      rd_total <= rd_total + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic b);
    fmem[wr_ptr[7:0]] = b;
    wr_ptr++;
  endtask

  task automatic recv(input int n, input int duty, output logic [63:0] word,
                      output logic [63:0] dmask, output int gaps, output int spurious);
    int   idx;
    int   budget;
    logic r;
    word = '0; dmask = '0; gaps = 0; spurious = 0; idx = 0; budget = 0;
    while (idx < n && budget < 3000) begin
      @(negedge clk);
      r = (int'($urandom_range(99)) < duty);
      bus.inReady = r;
      #1;
      if (bus.outEmpty) begin
        if (idx > 0) gaps++;
        if (bus.outSymbolDone) spurious++;
      end else if (r) begin
        word[idx]  = bus.outChip;
        if (bus.outSymbolDone) dmask[idx] = 1'b1;
        idx++;
      end else if (bus.outSymbolDone) begin
        spurious++;
      end
      budget++;
    end
    @(negedge clk);
    bus.inReady = 1'b0;
    #1;
    chk("recv_chip_count", 64'(idx), 64'(n));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] w, dm;
    int gaps, spur, rd0, nonempty, dones;

    rst = 1'b1;
    bus.inReady = 1'b1;
`ifdef OQPSK_CHIP_SPREADER_BYPASS_EN
    bus.inBypass = 1'b0;
`endif
    repeat (3) @(negedge clk);
    #1;
    chk("rst_empty", 64'(bus.outEmpty), 64'(1));
    chk("rst_chip",  64'(bus.outChip), 64'(0));
    chk("rst_rd",    64'(bus.outFifoReadEnable), 64'(0));
    chk("rst_done",  64'(bus.outSymbolDone), 64'(0));

    // Symbol 0 from a preloaded FIFO.
    push(1'b0); push(1'b0); push(1'b0); push(1'b0);
    bus.inReady = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    recv(32, 100, w, dm, gaps, spur);
    chk("sym0_first8", 64'(w[7:0]), 64'h9B);
    chk("sym0_word",   64'(w[31:0]), 64'h744AC39B);
    chk("sym0_done",   dm, 64'h0000_0000_8000_0000);
    chk("sym0_rd_cnt", 64'(rd_total), 64'(4));
    chk("sym0_rd_gap01", 64'(rd_time[1] - rd_time[0]), 64'(2));
    chk("sym0_rd_gap23", 64'(rd_time[3] - rd_time[2]), 64'(2));
    chk("sym0_empty_after", 64'(bus.outEmpty), 64'(1));

    // Symbol 1 then symbol 8, back to back.
    push(1'b1); push(1'b0); push(1'b0); push(1'b0);
    push(1'b0); push(1'b0); push(1'b0); push(1'b1);
    recv(64, 100, w, dm, gaps, spur);
    chk("sym1_sym8_word", w, {32'hDEE06931, 32'h44AC39B7});
    chk("sym1_sym8_done", dm, 64'h8000_0000_8000_0000);
    chk("sym1_sym8_gaps", 64'(gaps), 64'(0));

    // FIFO runs dry after two bits of symbol 11.
    rd0 = rd_total;
    push(1'b1); push(1'b1);
    nonempty = 0; dones = 0;
    repeat (20) begin
      @(negedge clk);
      bus.inReady = 1'b1;
      #1;
      if (!bus.outEmpty) nonempty++;
      if (bus.outSymbolDone) dones++;
    end
    chk("dry_rd_cnt",   64'(rd_total - rd0), 64'(2));
    chk("dry_rd_low",   64'(bus.outFifoReadEnable), 64'(0));
    chk("dry_nonempty", 64'(nonempty), 64'(0));
    chk("dry_done",     64'(dones), 64'(0));
    push(1'b0); push(1'b1);
    recv(32, 100, w, dm, gaps, spur);
    chk("sym11_word",   64'(w[31:0]), 64'h06931DEE);
    chk("sym11_rd_cnt", 64'(rd_total - rd0), 64'(4));

    // Symbols 5 and 14 under a 30% ready duty.
    push(1'b1); push(1'b0); push(1'b1); push(1'b0);
    push(1'b0); push(1'b1); push(1'b1); push(1'b1);
    recv(64, 30, w, dm, gaps, spur);
    chk("rand_word", w, {32'h31DEE069, 32'h39B744AC});
    chk("rand_done", dm, 64'h8000_0000_8000_0000);
    chk("rand_spurious_done", 64'(spur), 64'(0));

    // Reset after 17 chips of symbol 0 while symbol 1 is held.
    rd0 = rd_total;
    push(1'b0); push(1'b0); push(1'b0); push(1'b0);
    push(1'b1); push(1'b0); push(1'b0); push(1'b0);
    recv(17, 100, w, dm, gaps, spur);
    chk("mid_rd_cnt", 64'(rd_total - rd0), 64'(8));
    chk("mid_word17", 64'(w[16:0]), 64'(17'h0C39B));
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("mid_rst_empty", 64'(bus.outEmpty), 64'(1));
    chk("mid_rst_chip",  64'(bus.outChip), 64'(0));
    rst = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    chk("mid_discard_empty", 64'(bus.outEmpty), 64'(1));
    push(1'b1); push(1'b1); push(1'b0); push(1'b0);
    recv(32, 100, w, dm, gaps, spur);
    chk("post_rst_word", 64'(w[31:0]), 64'hAC39B744);
    chk("post_rst_done", dm, 64'h0000_0000_8000_0000);
    repeat (10) @(negedge clk);
    #1;
    chk("post_rst_idle_empty", 64'(bus.outEmpty), 64'(1));

`ifdef OQPSK_CHIP_SPREADER_BYPASS_EN
    bus.inBypass = 1'b1;
    repeat (2) @(negedge clk);
    push(1'b1); push(1'b0); push(1'b1);
    recv(3, 100, w, dm, gaps, spur);
    chk("bypass_chips", 64'(w[2:0]), 64'(3'b101));
    chk("bypass_done",  64'(dm[2:0]), 64'(3'b111));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/oqpsk_chip_spreader.md
Name: oqpsk_chip_spreader

Overview:
- Transmit-path stage between inFIFO and msk_modulator.
- Pulls serial data bits from inFIFO and groups them into 4-bit symbols.
- Maps each symbol to its 32-chip IEEE 802.15.4 (2.4 GHz) PN sequence and presents the chips serially to the modulator through an empty/ready handshake.
- Double-buffered, so chip flow is gap-free across symbol boundaries whenever the FIFO keeps up.

Parameters:
- RD_LATENCY, 1, cycles from inFIFO read-enable to valid read data; legal values 1 or 2.
- SYM_BITS, 4, data bits per symbol; fixed by standard, exposed for assertions only.

Ports:
- inClock  in  1  single clock.
- inReset  in  1  reset, synchronous, active-high.
- inFifoData  in  1  inFIFO outData.
- inFifoEmpty  in  1  inFIFO outEmpty.
- outFifoReadEnable  out  1  one-cycle pulse per bit fetched.
- inReady  in  1  modulator o_ready; a high cycle consumes the current chip.
- outChip  out  1  current chip to modulator i_data.
- outEmpty  out  1  high = no chip available; drives modulator i_empty.
- outSymbolDone  out  1  one-cycle pulse when chip 31 of a symbol is consumed.

Behaviour:
- Reset: all outputs 0 except outEmpty=1.
  - Fetch FSM returns to F_IDLE.
  - Bit counter, hold register, chip counter and valid flags clear.
  - Any partial symbol is discarded; this applies equally to a reset mid-operation.
- Fetch FSM states: F_IDLE, F_READ, F_WAIT, F_HOLD.
  - F_IDLE: go to F_READ when the hold register is not valid.
  - F_READ: if inFifoEmpty=0, pulse outFifoReadEnable and go to F_WAIT. Otherwise stay in F_READ with read-enable low; a read is never issued against an empty FIFO.
  - F_WAIT: after RD_LATENCY cycles, capture inFifoData into bit[bitcnt]. The first bit fetched is the symbol LSB. If bitcnt=3, set hold valid and go to F_HOLD; otherwise increment bitcnt and return to F_READ.
  - F_HOLD: wait until the hold register is transferred, then go to F_IDLE with bitcnt=0.
- Send path:
  - Holds a 32-bit chip shift register plus a 5-bit chip counter.
  - When the send register is empty, or chip 31 is being consumed, and hold is valid: load the table entry for the hold symbol and clear hold valid in the same cycle.
- Output rules:
  - outChip = shift register bit 0 (chip c0 is emitted first).
  - outEmpty = !sendValid.
- Handshake:
  - inReady high with outEmpty=0: shift right, increment the chip counter; the next chip is visible the following cycle.
  - inReady high with outEmpty=1: ignored.
  - Chip 31 consumed with hold valid: the next symbol's c0 appears the next cycle and outEmpty stays 0.
  - Chip 31 consumed with no hold: outEmpty=1 the next cycle.
  - outSymbolDone pulses in the cycle chip 31 is consumed.
- Chip table (c0 at bit 0):
  - Symbol 0 = 32'h744AC39B.
  - Symbols 1–7 = symbol 0 rotated left by 4·k chips (e.g. symbol 1 = 32'h44AC39B7).
  - Symbols 8–15 = symbols 0–7 XOR 32'hAAAAAAAA (odd chips inverted).
- Simultaneous events:
  - A load and a consume in the same cycle are legal.
  - Inputs are ignored in the reset cycle.
- Throughput: worst case is 4·(RD_LATENCY+1) cycles per symbol fetched against 32 chips sent, so the block never starves at one chip per cycle once primed.

Optional Feature:
- Macro: OQPSK_CHIP_SPREADER_BYPASS_EN.
- Defined:
  - Adds input port inBypass (1 bit).
  - When inBypass=1, each fetched bit is presented directly as a single chip, with no table lookup and no symbol grouping.
  - outSymbolDone pulses per bit.
  - Mode changes take effect only when send and hold are both empty.
- Undefined: no port is added and the spreading path is always used.

Decomposition:
- Package oqpsk_pkg holds:
  - localparam CHIPS_PER_SYM=32 and SYM_BITS=4;
  - typedef chip_seq_t = logic[31:0];
  - function chip_lut(sym) returning chip_seq_t;
  - enum fetch_state_t {F_IDLE, F_READ, F_WAIT, F_HOLD}.
- One sub-module, oqpsk_bit_collector, contains the fetch FSM, bit counter and hold register, exposing a hold valid/data/take interface. The send shift register stays in the top module.

Test Plan:
- Reset, then FIFO preloaded with bits 0,0,0,0 and inReady held high:
  - one read pulse per bit, spaced by RD_LATENCY+1;
  - outEmpty falls, and the first 8 chips are 1,1,0,1,1,0,0,1;
  - outSymbolDone pulses after 32 consumed chips.
- Bits 1,0,0,0 (symbol 1) followed by 0,0,0,1 (symbol 8):
  - symbol 1 emits 32'h44AC39B7 LSB-first;
  - symbol 8 emits 32'hDEE069 31 LSB-first, i.e. 32'h744AC39B ^ 32'hAAAAAAAA = 32'hDEE06931;
  - no outEmpty gap between the two symbols.
- FIFO empty after 2 bits:
  - outFifoReadEnable stays 0 while empty and outEmpty stays 1;
  - refill with 2 bits → the symbol completes with the correct LSB ordering.
- inReady toggled randomly at 30% duty:
  - the chip stream matches the reference model;
  - inReady during outEmpty=1 causes no shift and no outSymbolDone.
- inReset asserted at chip 17 of a symbol while a second symbol is held:
  - next cycle outEmpty=1 and outChip=0;
  - both symbols are discarded, and after release a fresh 4-bit fetch starts from bit 0.
- With OQPSK_CHIP_SPREADER_BYPASS_EN defined and inBypass=1, bits 1,0,1:
  - chips out are 1,0,1;
  - one outSymbolDone pulse per chip.
